// File: rtl/icache_if.sv
// Fetch-side and memory-side handshake bundle for the instruction cache.
// The cache uses the slave view; whoever drives fetch requests and memory replies uses master.
interface icache_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_if_enable;
    logic [31:0] mem_inst_addr;
    logic        mem_if_ready;
    logic [31:0] mem_inst;

    modport slave (
        input  fetch_valid, fetch_pc, mem_if_ready, mem_inst,
        output fetch_ready, fetch_inst, mem_if_enable, mem_inst_addr
    );

    modport master (
        output fetch_valid, fetch_pc, mem_if_ready, mem_inst,
        input  fetch_ready, fetch_inst, mem_if_enable, mem_inst_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-latency hits
// and a single outstanding miss toward the memory controller.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 18
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear,
    icache_if.slave  bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - 2 - INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state;
    state_t                next_state;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [31:0]           data_q [LINES];
    logic [31:0]           miss_addr;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  start_miss;
    logic                  fill;
    logic                  unused_pc_bits;

    assign req_index  = bus.fetch_pc[INDEX_BITS+1:2];
    assign req_tag    = bus.fetch_pc[ADDR_BITS-1:INDEX_BITS+2];
    assign fill_index = miss_addr[INDEX_BITS+1:2];
    assign fill_tag   = miss_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign unused_pc_bits = ^{bus.fetch_pc[31:ADDR_BITS], bus.fetch_pc[1:0]};

    assign hit = bus.fetch_valid & valid_q[req_index] & (tag_q[req_index] == req_tag);

    assign bus.mem_if_enable = (state == MISS);
    assign bus.mem_inst_addr = miss_addr;

    // Hits are answered only from IDLE; a clear aborts a miss and wins over a same-cycle fill.
    always_comb begin
        next_state     = state;
        start_miss     = 1'b0;
        fill           = 1'b0;
        bus.fetch_ready = 1'b0;
        bus.fetch_inst  = 32'h0;
        case (state)
            IDLE: begin
                if (hit) begin
                    bus.fetch_inst = data_q[req_index];
                end
                bus.fetch_ready = hit & rdy_in & ~clear;
                if (bus.fetch_valid & ~hit & rdy_in & ~clear) begin
                    start_miss = 1'b1;
                    next_state = MISS;
                end
            end
            MISS: begin
                if (rdy_in) begin
                    if (clear) begin
                        next_state = IDLE;
                    end else if (bus.mem_if_ready) begin
                        fill       = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q   <= '0;
            miss_addr <= 32'h0;
        end else begin
            if (start_miss) begin
                miss_addr <= {bus.fetch_pc[31:2], 2'b00};
            end
            if (fill) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits gate every use.
    always_ff @(posedge clk_in) begin
        if (fill) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= bus.mem_inst;
        end
    end
endmodule
